// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between the instruction fetch (IF) stage and the
// data memory (MEM) stage. Each access is sequenced through IDLE -> FETCH/DATA
// -> IDLE. Every output except the two stalls is registered, so no
// combinational path runs from m_ready to an output. A sticky err flag records
// any access that the memory never answered within TIMEOUT cycles.
module mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              reset,
   // fetch port
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_valid,
   output logic              if_stall,
   // data port
   input  logic              mem_req,
   input  logic              mem_we,
   input  logic              mem_byte,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              mem_valid,
   output logic              mem_stall,
   // memory side
   output logic              m_req,
   output logic              m_we,
   output logic              m_byte,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   input  logic [DATA_W-1:0] m_rdata,
   input  logic              m_ready,
   output logic              err
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic              last_data, last_data_nxt;
   logic              m_req_nxt, m_we_nxt, m_byte_nxt;
   logic [ADDR_W-1:0] m_addr_nxt;
   logic [DATA_W-1:0] m_wdata_nxt, if_rdata_nxt, mem_rdata_nxt;
   logic              if_valid_nxt, mem_valid_nxt, err_nxt;

   logic if_elig, mem_elig, grant_data, grant_fetch, timeout;

   // A port pulsing valid this cycle is advancing; its req/addr are stale.
   assign if_elig  = if_req & ~if_valid;
   assign mem_elig = mem_req & ~mem_valid;

   // Data wins unless it also won last time and fetch is waiting.
   assign grant_data  = mem_elig & ~(last_data & if_elig);
   assign grant_fetch = if_elig & ~grant_data;

   // The counter holds the number of active cycles already spent without
   // m_ready; the last allowed cycle is the one where it equals TIMEOUT-1.
   assign timeout = (cnt == CNT_W'(TIMEOUT - 1));

   assign if_stall  = if_req & ~if_valid;
   assign mem_stall = mem_req & ~mem_valid;

   // Next-state and next-output logic for the access sequencer.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves
      // one unassigned, which would infer a latch.
      state_nxt     = state;
      cnt_nxt       = cnt;
      last_data_nxt = last_data;
      m_req_nxt     = m_req;
      m_we_nxt      = m_we;
      m_byte_nxt    = m_byte;
      m_addr_nxt    = m_addr;
      m_wdata_nxt   = m_wdata;
      if_rdata_nxt  = if_rdata;
      mem_rdata_nxt = mem_rdata;
      if_valid_nxt  = 1'b0;
      mem_valid_nxt = 1'b0;
      err_nxt       = err;

      case (state)
         IDLE: begin
            if (grant_data) begin
               state_nxt     = DATA;
               last_data_nxt = 1'b1;
               cnt_nxt       = '0;
               m_req_nxt     = 1'b1;
               m_we_nxt      = mem_we;
               m_byte_nxt    = mem_byte;
               m_addr_nxt    = mem_addr;
               m_wdata_nxt   = mem_wdata;
            end else if (grant_fetch) begin
               state_nxt     = FETCH;
               last_data_nxt = 1'b0;
               cnt_nxt       = '0;
               m_req_nxt     = 1'b1;
               m_we_nxt      = 1'b0;
               m_byte_nxt    = 1'b0;
               m_addr_nxt    = if_addr;
               m_wdata_nxt   = '0;
            end
         end
         FETCH, DATA: begin
            if (m_ready || timeout) begin
               state_nxt = IDLE;
               m_req_nxt = 1'b0;
               if (!m_ready) err_nxt = 1'b1;
               if (state == FETCH) begin
                  if_valid_nxt = 1'b1;
                  if_rdata_nxt = m_ready ? m_rdata : '0;
               end else begin
                  mem_valid_nxt = 1'b1;
                  mem_rdata_nxt = (m_ready && !m_we) ? m_rdata : '0;
               end
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State and registered outputs; reset drops any in-flight access.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         cnt       <= '0;
         last_data <= 1'b0;
         m_req     <= 1'b0;
         m_we      <= 1'b0;
         m_byte    <= 1'b0;
         m_addr    <= '0;
         m_wdata   <= '0;
         if_rdata  <= '0;
         mem_rdata <= '0;
         if_valid  <= 1'b0;
         mem_valid <= 1'b0;
         err       <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values regardless of statement order.
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         last_data <= last_data_nxt;
         m_req     <= m_req_nxt;
         m_we      <= m_we_nxt;
         m_byte    <= m_byte_nxt;
         m_addr    <= m_addr_nxt;
         m_wdata   <= m_wdata_nxt;
         if_rdata  <= if_rdata_nxt;
         mem_rdata <= mem_rdata_nxt;
         if_valid  <= if_valid_nxt;
         mem_valid <= mem_valid_nxt;
         err       <= err_nxt;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. The bench plays the memory; expected
// completions are queued when requests are driven and popped on each valid.
module tb_mem_arbiter;

   logic        clk, reset;
   logic        if_req, mem_req, mem_we, mem_byte, m_ready;
   logic [31:0] if_addr, mem_addr, mem_wdata, m_rdata;
   logic [31:0] if_rdata, mem_rdata, m_addr, m_wdata;
   logic        if_valid, if_stall, mem_valid, mem_stall;
   logic        m_req, m_we, m_byte, err;

   typedef struct {
      bit          is_data;
      logic [31:0] rdata;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   if_pulses = 0;
   int   mem_pulses = 0;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
      .if_valid(if_valid), .if_stall(if_stall),
      .mem_req(mem_req), .mem_we(mem_we), .mem_byte(mem_byte),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_valid(mem_valid), .mem_stall(mem_stall),
      .m_req(m_req), .m_we(m_we), .m_byte(m_byte), .m_addr(m_addr),
      .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ready(m_ready), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count completion pulses independently of the directed sequence.
   always @(negedge clk) begin
      if (if_valid)  if_pulses++;
      if (mem_valid) mem_pulses++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // Wait for the access to start, verify the memory-side request, hold it
   // for lat cycles, then answer with data. Returns at the valid cycle.
   task automatic serve(input int lat, input logic [31:0] data, input logic [31:0] addr,
                        input logic we, input logic exp_byte, input logic [31:0] wdata,
                        input string tag);
      int n = 0;
      while (!m_req && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({tag, " m_req"}, 32'(m_req), 32'd1);
      check({tag, " m_addr"}, m_addr, addr);
      check({tag, " m_we"}, 32'(m_we), 32'(we));
      check({tag, " m_byte"}, 32'(m_byte), 32'(exp_byte));
      check({tag, " m_wdata"}, m_wdata, wdata);
      for (int i = 1; i < lat; i++) begin
         m_rdata = 32'hBAD0_0000 | 32'(i);
         @(negedge clk);
         check({tag, " m_addr hold"}, m_addr, addr);
         check({tag, " m_req hold"}, 32'(m_req), 32'd1);
      end
      m_ready = 1'b1;
      m_rdata = data;
      @(negedge clk);
      m_ready = 1'b0;
      m_rdata = 32'hBAD0_BAD0;
   endtask

   // Compare the next completion against the head of the scoreboard.
   task automatic pop_check(input string tag);
      int   n = 0;
      exp_t e;
      while (!(if_valid || mem_valid) && n < 10) begin
         @(negedge clk);
         n++;
      end
      check({tag, " sb nonempty"}, 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         check({tag, " valid port"}, 32'({if_valid, mem_valid}),
               e.is_data ? 32'd1 : 32'd2);
         check({tag, " rdata"}, e.is_data ? mem_rdata : if_rdata, e.rdata);
      end
   endtask

   initial begin
      int n;
      int if_base;
      reset = 1'b0;
      if_req = 0; if_addr = 0; mem_req = 0; mem_we = 0; mem_byte = 0;
      mem_addr = 0; mem_wdata = 0; m_ready = 0; m_rdata = 0;

      // reset state
      repeat (2) @(negedge clk);
      check("rst m_req", 32'(m_req), 32'd0);
      check("rst m_addr", m_addr, 32'd0);
      check("rst valids", 32'({if_valid, mem_valid}), 32'd0);
      check("rst err", 32'(err), 32'd0);
      reset = 1'b1;
      @(negedge clk);

      // single fetch, memory answers on the first active cycle
      if_req = 1'b1; if_addr = 32'h10;
      sb.push_back('{is_data: 1'b0, rdata: 32'hE3A0_0001});
      #1 check("t1 stall c0", 32'(if_stall), 32'd1);
      @(negedge clk);
      check("t1 stall c1", 32'(if_stall), 32'd1);
      serve(1, 32'hE3A0_0001, 32'h10, 1'b0, 1'b0, 32'h0, "t1");
      pop_check("t1");
      check("t1 stall c2", 32'(if_stall), 32'd0);
      if_req = 1'b0;
      @(negedge clk);
      check("t1 no regrant", 32'(m_req), 32'd0);
      check("t1 valid once", 32'(if_valid), 32'd0);
      check("t1 rdata hold", if_rdata, 32'hE3A0_0001);

      // simultaneous requests: data first, then fetch, then the next load
      if_req = 1'b1; if_addr = 32'h20;
      mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h100;
      sb.push_back('{is_data: 1'b1, rdata: 32'h1111_1111});
      sb.push_back('{is_data: 1'b0, rdata: 32'h2222_2222});
      sb.push_back('{is_data: 1'b1, rdata: 32'h3333_3333});
      #1 check("t2 mem_stall", 32'(mem_stall), 32'd1);
      serve(1, 32'h1111_1111, 32'h100, 1'b0, 1'b0, 32'h0, "t2 ld0");
      pop_check("t2 ld0");
      mem_addr = 32'h104;
      serve(1, 32'h2222_2222, 32'h20, 1'b0, 1'b0, 32'h0, "t2 if");
      pop_check("t2 if");
      if_req = 1'b0;
      serve(1, 32'h3333_3333, 32'h104, 1'b0, 1'b0, 32'h0, "t2 ld1");
      pop_check("t2 ld1");
      mem_req = 1'b0;
      @(negedge clk);

      // after a data grant, a fresh simultaneous pair goes to fetch first
      if_req = 1'b1; if_addr = 32'h30;
      mem_req = 1'b1; mem_addr = 32'h108;
      sb.push_back('{is_data: 1'b0, rdata: 32'h4444_4444});
      sb.push_back('{is_data: 1'b1, rdata: 32'h5555_5555});
      serve(2, 32'h4444_4444, 32'h30, 1'b0, 1'b0, 32'h0, "t2 fair if");
      pop_check("t2 fair if");
      if_req = 1'b0;
      serve(1, 32'h5555_5555, 32'h108, 1'b0, 1'b0, 32'h0, "t2 fair ld");
      pop_check("t2 fair ld");
      mem_req = 1'b0;
      @(negedge clk);

      // byte store: memory data must not reach mem_rdata
      mem_req = 1'b1; mem_we = 1'b1; mem_byte = 1'b1;
      mem_addr = 32'h203; mem_wdata = 32'hAB;
      sb.push_back('{is_data: 1'b1, rdata: 32'h0});
      serve(1, 32'hDEAD_BEEF, 32'h203, 1'b1, 1'b1, 32'hAB, "t3");
      pop_check("t3");
      mem_req = 1'b0; mem_we = 1'b0; mem_byte = 1'b0;
      @(negedge clk);
      check("t3 valid once", 32'(mem_valid), 32'd0);

      // timeout: fetch never answered (mem_wdata left non-zero on purpose)
      if_req = 1'b1; if_addr = 32'h40;
      sb.push_back('{is_data: 1'b0, rdata: 32'h0});
      n = 0;
      while (!m_req && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("t4 err before", 32'(err), 32'd0);
      check("t4 fetch wdata", m_wdata, 32'h0);
      n = 0;
      while (m_req && n < 40) begin
         n++;
         @(negedge clk);
      end
      check("t4 active cycles", 32'(n), 32'd16);
      check("t4 err set", 32'(err), 32'd1);
      pop_check("t4");
      if_req = 1'b0;
      @(negedge clk);
      mem_req = 1'b1; mem_addr = 32'h300; mem_wdata = 32'h0;
      sb.push_back('{is_data: 1'b1, rdata: 32'h6666_6666});
      serve(1, 32'h6666_6666, 32'h300, 1'b0, 1'b0, 32'h0, "t4 after");
      pop_check("t4 after");
      check("t4 err sticky", 32'(err), 32'd1);
      mem_req = 1'b0;
      @(negedge clk);

      // reset in the middle of a data access
      mem_req = 1'b1; mem_addr = 32'h400;
      n = 0;
      while (!m_req && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("t5 in DATA", 32'(m_req), 32'd1);
      reset = 1'b0;
      m_ready = 1'b1; m_rdata = 32'h7777_7777;
      mem_req = 1'b0;
      #1;
      check("t5 m_req", 32'(m_req), 32'd0);
      check("t5 m_addr", m_addr, 32'd0);
      check("t5 err", 32'(err), 32'd0);
      check("t5 rdata", mem_rdata | if_rdata, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("t5 stale ready", 32'({if_valid, mem_valid, m_req}), 32'd0);
      m_ready = 1'b0;
      @(negedge clk);
      check("t5 still idle", 32'({if_valid, mem_valid, m_req}), 32'd0);

      // back-to-back fetches with three-cycle memory latency
      if_base = if_pulses;
      if_req = 1'b1;
      for (int k = 0; k < 3; k++) begin
         if_addr = 32'h50 + 32'(4 * k);
         sb.push_back('{is_data: 1'b0, rdata: 32'hA000_0000 + 32'(k)});
         serve(3, 32'hA000_0000 + 32'(k), 32'h50 + 32'(4 * k), 1'b0, 1'b0, 32'h0, "t6");
         pop_check("t6");
         if (k == 2) if_req = 1'b0;
         @(negedge clk);
         check("t6 no grant in valid cycle", 32'(m_req), 32'd0);
      end
      @(negedge clk);
      check("t6 pulse count", 32'(if_pulses - if_base), 32'd3);
      check("sb drained", 32'(sb.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
